// File: rtl/sha3_row_bus_arbiter.sv
// rtl/sha3_row_bus_arbiter.sv - shares one Keccak-f[1600] core between two requesters
// Round-robin dispatch from one-entry buffers, owner FIFO routes in-order results back.
module sha3_row_bus_arbiter #(
  parameter int MAX_INFLIGHT = 4,
  parameter int ID_W         = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_sample,
  input  logic [1599:0] req_state0,
  input  logic [1599:0] req_state1,
  output logic [1:0]    req_ready,
  output logic          core_sample,
  output logic [1599:0] core_state,
  input  logic          core_res_sample,
  input  logic [1599:0] core_res_state,
  output logic [1:0]    res_sample,
  output logic [1599:0] res_state,
  output logic          busy,
  output logic [1:0]    err_overrun,
  output logic          err_spurious
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [1599:0]    buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]       full_q, full_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  fifo_q [MAX_INFLIGHT];
  logic [ID_W-1:0]  fifo_d [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             core_sample_q, core_sample_d;
  logic [1599:0]    core_state_q, core_state_d;
  logic [1:0]       res_sample_q, res_sample_d;
  logic [1599:0]    res_state_q, res_state_d;
  logic             busy_q, busy_d;
  logic [1:0]       err_overrun_q, err_overrun_d;
  logic             err_spurious_q, err_spurious_d;

  logic             grant_v, credit_ok, fifo_empty, push, pop, bypass, res_v;
  logic [ID_W-1:0]  grant_id, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    full_d         = full_q;
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    res_sample_d   = 2'b00;
    res_state_d    = res_state_q;
    core_state_d   = core_state_q;
    grant_v        = 1'b0;
    grant_id       = '0;

    fifo_empty = (inflight_q == '0);
    // A result popping at full credit frees the slot the same-cycle grant takes.
    credit_ok  = (inflight_q < CNT_W'(MAX_INFLIGHT)) | (core_res_sample & ~fifo_empty);
    if ((full_q != 2'b00) && credit_ok) begin
      grant_v  = 1'b1;
      grant_id = (&full_q) ? ~last_grant_q : ID_W'(full_q[1]);
    end
    last_grant_d  = grant_v ? grant_id : last_grant_q;
    core_sample_d = grant_v;
    if (grant_v) begin
      core_state_d     = (grant_id == ID_W'(1)) ? buf1_q : buf0_q;
      full_d[grant_id] = 1'b0;
    end

    if (req_sample[0] && !full_q[0]) begin
      full_d[0] = 1'b1;
      buf0_d    = req_state0;
    end
    if (req_sample[1] && !full_q[1]) begin
      full_d[1] = 1'b1;
      buf1_d    = req_state1;
    end
    err_overrun_d = err_overrun_q | (req_sample & full_q);

    // Result arriving with an empty FIFO but a same-cycle grant takes that grant's ID directly.
    bypass = core_res_sample & fifo_empty & grant_v;
    pop    = core_res_sample & ~fifo_empty;
    push   = grant_v & ~bypass;
    head   = bypass ? grant_id : fifo_q[rd_ptr_q];
    res_v  = pop | bypass;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    inflight_d = inflight_q + CNT_W'(push) - CNT_W'(pop);
    if (res_v) begin
      res_sample_d[head] = 1'b1;
      res_state_d        = core_res_state;
    end
    err_spurious_d = err_spurious_q | (core_res_sample & ~res_v);
    busy_d         = (full_d != 2'b00) | (inflight_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q         <= '0;
      buf1_q         <= '0;
      full_q         <= 2'b00;
      last_grant_q   <= ID_W'(1);
      for (int i = 0; i < MAX_INFLIGHT; i++) fifo_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= '0;
      core_sample_q  <= 1'b0;
      core_state_q   <= '0;
      res_sample_q   <= 2'b00;
      res_state_q    <= '0;
      busy_q         <= 1'b0;
      err_overrun_q  <= 2'b00;
      err_spurious_q <= 1'b0;
    end else begin
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      full_q         <= full_d;
      last_grant_q   <= last_grant_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= inflight_d;
      core_sample_q  <= core_sample_d;
      core_state_q   <= core_state_d;
      res_sample_q   <= res_sample_d;
      res_state_q    <= res_state_d;
      busy_q         <= busy_d;
      err_overrun_q  <= err_overrun_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign req_ready    = ~full_q;
  assign core_sample  = core_sample_q;
  assign core_state   = core_state_q;
  assign res_sample   = res_sample_q;
  assign res_state    = res_state_q;
  assign busy         = busy_q;
  assign err_overrun  = err_overrun_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_sha3_row_bus_arbiter.sv
// tb/tb_sha3_row_bus_arbiter.sv - self-checking bench for sha3_row_bus_arbiter
// Vector table plus directed sequences; scoreboard queues hold expected dispatches/results.
module tb_sha3_row_bus_arbiter;

  localparam logic [1599:0] KMASK = {25{64'hF0E1D2C3B4A59687}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_sample = 2'b00;
  logic [1599:0] req_state0 = '0;
  logic [1599:0] req_state1 = '0;
  logic [1:0]    req_ready;
  logic          core_sample;
  logic [1599:0] core_state;
  logic          core_res_sample = 1'b0;
  logic [1599:0] core_res_state = '0;
  logic [1:0]    res_sample;
  logic [1599:0] res_state;
  logic          busy;
  logic [1:0]    err_overrun;
  logic          err_spurious;

  always #5 clk = ~clk;

  sha3_row_bus_arbiter #(.MAX_INFLIGHT(4), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_sample(req_sample), .req_state0(req_state0), .req_state1(req_state1),
    .req_ready(req_ready),
    .core_sample(core_sample), .core_state(core_state),
    .core_res_sample(core_res_sample), .core_res_state(core_res_state),
    .res_sample(res_sample), .res_state(res_state),
    .busy(busy), .err_overrun(err_overrun), .err_spurious(err_spurious)
  );

  typedef struct {
    logic [1:0]    id;
    logic [1599:0] st;
  } res_t;

  typedef struct {
    logic [1:0] mask;
    int         n;
    int         ord0;
    int         ord1;
  } vec_t;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [1599:0] exp_disp[$];
  logic [1599:0] core_q[$];
  int            core_t[$];
  res_t          exp_res[$];
  bit core_auto = 1'b1;
  int core_lat = 8;
  int force_ret = 0;
  bit spur_req = 1'b0;
  int disp_count = 0;
  int last_disp_cyc = 0;
  int last_ret_cyc = 0;
  int last_res_cyc = 0;
  int low_run[2] = '{0, 0};
  int max_low[2] = '{0, 0};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1599:0] mk(input int id, input int k, input int tag);
    logic [1599:0] s;
    for (int l = 0; l < 25; l++) s[64*l +: 64] = {16'(tag), 8'(l), 24'h0, 8'(id), 8'(k)};
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: dispatches and results compared in order as the DUT produces them.
  always @(negedge clk) begin
    logic [1599:0] e;
    res_t r;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_ready[i]) begin
          low_run[i]++;
          if (low_run[i] > max_low[i]) max_low[i] = low_run[i];
        end else begin
          low_run[i] = 0;
        end
      end
      if (core_sample) begin
        disp_count++;
        last_disp_cyc = cyc;
        core_q.push_back(core_state);
        core_t.push_back(cyc);
        chk("disp_queue", exp_disp.size() != 0, core_state[63:0], 0);
        if (exp_disp.size() != 0) begin
          e = exp_disp.pop_front();
          chk("disp_state", core_state === e, core_state[63:0], e[63:0]);
        end
      end
      if (res_sample != 2'b00) begin
        last_res_cyc = cyc;
        chk("res_queue", exp_res.size() != 0, res_sample, 0);
        if (exp_res.size() != 0) begin
          r = exp_res.pop_front();
          chk("res_owner", res_sample === r.id, res_sample, r.id);
          chk("res_state", res_state === r.st, res_state[63:0], r.st[63:0]);
        end
      end
    end
  end

  // In-order core model: returns each dispatched state XOR KMASK after core_lat cycles.
  always @(posedge clk) begin
    logic [1599:0] s;
    res_t r;
    #2;
    core_res_sample = 1'b0;
    if (spur_req) begin
      core_res_sample = 1'b1;
      core_res_state  = KMASK;
      spur_req        = 1'b0;
      last_ret_cyc    = cyc;
    end else if (core_q.size() != 0 && ((core_auto && cyc >= core_t[0] + core_lat) || force_ret > 0)) begin
      s = core_q.pop_front();
      void'(core_t.pop_front());
      core_res_sample = 1'b1;
      core_res_state  = s ^ KMASK;
      r.id = (s[15:8] == 8'd0) ? 2'b01 : 2'b10;
      r.st = s ^ KMASK;
      exp_res.push_back(r);
      if (force_ret > 0) force_ret--;
      last_ret_cyc = cyc;
    end
  end

  task automatic drain(input string nm);
    int n = 0;
    while ((busy || exp_disp.size() != 0 || core_q.size() != 0 || exp_res.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, n < 300, n, 300);
  endtask

  task automatic single_req(input string nm);
    logic [1599:0] st;
    int t0;
    st = '0;
    st[63:0] = 64'h1;
    core_auto = 1'b1;
    core_lat = 8;
    exp_disp.push_back(st);
    req_state0 = st;
    req_sample = 2'b01;
    t0 = cyc;
    step();
    req_sample = 2'b00;
    chk({nm, "_ready_c1"}, req_ready === 2'b10, req_ready, 2'b10);
    chk({nm, "_busy_c1"}, busy === 1'b1, busy, 1);
    step();
    chk({nm, "_core_sample_c2"}, core_sample === 1'b1, core_sample, 1);
    chk({nm, "_ready_c2"}, req_ready === 2'b11, req_ready, 2'b11);
    drain(nm);
    chk({nm, "_disp_cycle"}, last_disp_cyc - t0 == 2, last_disp_cyc - t0, 2);
    chk({nm, "_res_cycle"}, last_res_cyc - t0 == 11, last_res_cyc - t0, 11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int sent[2];
    int d0;
    int n;

    // Grant order hand-derived from round-robin history (last_grant is 0 after single_req).
    vt[0] = '{mask: 2'b01, n: 1, ord0: 0, ord1: 0};
    vt[1] = '{mask: 2'b10, n: 1, ord0: 1, ord1: 0};
    vt[2] = '{mask: 2'b11, n: 2, ord0: 0, ord1: 1};
    vt[3] = '{mask: 2'b11, n: 2, ord0: 0, ord1: 1};
    vt[4] = '{mask: 2'b01, n: 1, ord0: 0, ord1: 0};
    vt[5] = '{mask: 2'b11, n: 2, ord0: 1, ord1: 0};
    vt[6] = '{mask: 2'b10, n: 1, ord0: 1, ord1: 0};

    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", req_ready === 2'b11, req_ready, 2'b11);
    chk("rst_core_sample", core_sample === 1'b0, core_sample, 0);
    chk("rst_res_sample", res_sample === 2'b00, res_sample, 0);
    chk("rst_core_state", core_state === '0, core_state[63:0], 0);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_errs", {err_overrun, err_spurious} === 3'b000, {err_overrun, err_spurious}, 0);

    single_req("t1");

    core_lat = 3;
    for (int v = 0; v < 7; v++) begin
      d0 = disp_count;
      for (int j = 0; j < vt[v].n; j++)
        exp_disp.push_back(mk((j == 0) ? vt[v].ord0 : vt[v].ord1, v, 16'h7AB0));
      req_state0 = mk(0, v, 16'h7AB0);
      req_state1 = mk(1, v, 16'h7AB0);
      req_sample = vt[v].mask;
      step();
      req_sample = 2'b00;
      chk($sformatf("vec%0d_ready", v), req_ready === ~vt[v].mask, req_ready, ~vt[v].mask);
      drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_count", v), disp_count - d0 == vt[v].n, disp_count - d0, vt[v].n);
    end

    core_lat = 2;
    max_low = '{0, 0};
    for (int k = 0; k < 6; k++) begin
      exp_disp.push_back(mk(0, k, 16'h2222));
      exp_disp.push_back(mk(1, k, 16'h2222));
    end
    sent = '{0, 0};
    d0 = disp_count;
    n = 0;
    while ((sent[0] < 6 || sent[1] < 6) && n < 200) begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i] && sent[i] < 6) begin
          req_sample[i] = 1'b1;
          if (i == 0) req_state0 = mk(0, sent[0], 16'h2222);
          else        req_state1 = mk(1, sent[1], 16'h2222);
          sent[i]++;
        end else begin
          req_sample[i] = 1'b0;
        end
      end
      step();
      n++;
    end
    req_sample = 2'b00;
    drain("t2");
    chk("t2_count", disp_count - d0 == 12, disp_count - d0, 12);
    chk("t2_ready_low0", max_low[0] <= 2, max_low[0], 2);
    chk("t2_ready_low1", max_low[1] <= 2, max_low[1], 2);

    core_auto = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_disp.push_back(mk(0, k, 16'h3C3C));
      exp_disp.push_back(mk(1, k, 16'h3C3C));
    end
    sent = '{0, 0};
    d0 = disp_count;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i] && sent[i] < 3) begin
          req_sample[i] = 1'b1;
          if (i == 0) req_state0 = mk(0, sent[0], 16'h3C3C);
          else        req_state1 = mk(1, sent[1], 16'h3C3C);
          sent[i]++;
        end else begin
          req_sample[i] = 1'b0;
        end
      end
      step();
    end
    req_sample = 2'b00;
    chk("t3_credit_count", disp_count - d0 == 4, disp_count - d0, 4);
    chk("t3_busy", busy === 1'b1, busy, 1);
    chk("t3_ready", req_ready === 2'b00, req_ready, 2'b00);

    req_state1 = mk(1, 99, 16'hBAD0);
    req_sample = 2'b10;
    step();
    req_sample = 2'b00;
    chk("t5_overrun", err_overrun === 2'b10, err_overrun, 2'b10);

    force_ret = 1;
    for (int c = 0; c < 6; c++) step();
    chk("t4_one_more", disp_count - d0 == 5, disp_count - d0, 5);
    chk("t4_same_cycle", last_disp_cyc == last_ret_cyc + 1, last_disp_cyc, last_ret_cyc + 1);
    chk("t4_ready", req_ready === 2'b01, req_ready, 2'b01);
    core_lat = 1;
    core_auto = 1'b1;
    drain("t3");
    chk("t5_overrun_sticky", err_overrun === 2'b10, err_overrun, 2'b10);

    core_auto = 1'b0;
    exp_disp.push_back(mk(0, 0, 16'h6666));
    exp_disp.push_back(mk(1, 0, 16'h6666));
    req_state0 = mk(0, 0, 16'h6666);
    req_state1 = mk(1, 0, 16'h6666);
    req_sample = 2'b11;
    step();
    req_sample = 2'b00;
    step();
    step();
    req_state0 = mk(0, 1, 16'h6666);
    req_state1 = mk(1, 1, 16'h6666);
    req_sample = 2'b11;
    step();
    req_sample = 2'b00;
    chk("t6_pre_ready", req_ready === 2'b00, req_ready, 2'b00);
    chk("t6_pre_inflight", core_q.size() == 2, core_q.size(), 2);
    #2;
    rst_n = 1'b0;
    exp_disp.delete();
    core_q.delete();
    core_t.delete();
    exp_res.delete();
    #1;
    chk("t6_rst_ready", req_ready === 2'b11, req_ready, 2'b11);
    chk("t6_rst_busy", busy === 1'b0, busy, 0);
    chk("t6_rst_core_state", core_state === '0, core_state[63:0], 0);
    chk("t6_rst_res", {res_sample, core_sample} === 3'b000, {res_sample, core_sample}, 0);
    chk("t6_rst_res_state", res_state === '0, res_state[63:0], 0);
    chk("t6_rst_errs", {err_overrun, err_spurious} === 3'b000, {err_overrun, err_spurious}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    spur_req = 1'b1;
    step();
    chk("t5_spurious", err_spurious === 1'b1, err_spurious, 1);
    chk("t5_spur_res0", res_sample === 2'b00, res_sample, 0);
    step();
    chk("t5_spur_res1", res_sample === 2'b00, res_sample, 0);

    single_req("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sha3_row_bus_arbiter.md
Name: sha3_row_bus_arbiter

Overview:
- Shares one Keccak-f[1600] permutation core between two requesters.
- Each requester owns a one-entry state buffer. The arbiter grants the core round-robin and tracks in-flight ownership in an ID FIFO.
- Each result is routed back to the requester that issued it.
- Sits between the absorb/squeeze front-ends and the permutation core, on the flattened 1600-bit row-bus format: lane (r,c) at bits [64*(5*r+c) +: 64], row a is r=0.

Parameters:
- MAX_INFLIGHT, 4: maximum permutations outstanding in the core; depth of the owner FIFO; must be ≥1.
- ID_W, 1: owner tag width; fixed for 2 requesters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_sample[2]  in  2  per-requester: state on req_state valid this cycle.
- req_state0, req_state1  in  1600 each  requester states, row-bus layout.
- req_ready[2]  out  2  buffer of requester i empty; sample accepted.
- core_sample  out  1  one-cycle strobe; core_state valid.
- core_state  out  1600  state dispatched to core.
- core_res_sample  in  1  core result valid, one cycle.
- core_res_state  in  1600  core result.
- res_sample[2]  out  2  result for requester i valid, one cycle.
- res_state  out  1600  result state, shared by both requesters.
- busy  out  1  any buffer full or inflight > 0.
- err_overrun[2]  out  2  sticky: req_sample_i seen while req_ready_i low.
- err_spurious  out  1  sticky: core_res_sample with owner FIFO empty.

Behaviour:
- Reset (async assert, sync deassert by the system) has the following effects:
  - Buffers empty; req_ready = 2'b11.
  - core_sample = 0, res_sample = 0, core_state and res_state = 0.
  - Owner FIFO empty, inflight = 0, RR pointer last_grant = 1, so requester 0 wins first.
  - busy = 0, all err flags = 0.
- Capture: req_sample_i & req_ready_i in cycle t loads buffer i at the end of t. req_ready_i is low from t+1.
- Overrun: req_sample_i while req_ready_i is low ignores the data and sets err_overrun_i. It stays set until reset.
- Dispatch decision is made each cycle, at most one grant:
  - Eligible when at least one buffer is full and inflight < MAX_INFLIGHT.
  - Only one buffer full: grant it.
  - Both full: grant the requester != last_grant.
  - On grant in cycle t:
    - core_state is loaded from the buffer and core_sample = 1 during t+1.
    - The buffer is cleared, so req_ready_i is high in t+1.
    - The ID is pushed to the owner FIFO and last_grant is updated.
  - core_sample is never high in two cycles for the same buffer content.
- Latency: req_sample in cycle 0 → buffer full in cycle 1 → core_sample in cycle 2, with no contention. Back-to-back dispatch at 1 per cycle is possible when both buffers are full.
- Credits: inflight increments on push and decrements on pop. Simultaneous push and pop leaves it unchanged, so a grant is allowed in the same cycle a result pops at inflight = MAX_INFLIGHT.
- Return: core_res_sample in cycle t pops the FIFO head h. During t+1, res_sample[h] = 1 and res_state = core_res_state registered. Results are returned in dispatch order; the core is required to be in-order.
- Spurious result: core_res_sample with the FIFO empty (and no same-cycle push) is dropped, sets err_spurious, and leaves res_sample low.
- Requesters have no backpressure on results: res_sample is a strobe that must be consumed.
- Reset mid-operation discards buffers and the FIFO. The core is reset together with the arbiter; any result arriving after reset is flagged spurious.
- busy is registered from next-state values: buffer full or inflight ≠ 0.

Test Plan:
1. Single request: req_sample[0] in cycle 0 with lane(0,0) = 64'h1 → core_sample in cycle 2 with core_state lane(0,0) = 64'h1; req_ready[0] low in cycles 1 only. Core returns in cycle 10 → res_sample = 2'b01 in cycle 11 with the same state.
2. Contention fairness: both requesters sample in cycle 0 and refill immediately on ready, for 6 requests each → core_sample grant order 0,1,0,1,…; no req_ready low longer than 2 cycles; results routed 0,1,0,1.
3. Credit limit, MAX_INFLIGHT = 4: with no results returning, issue 6 requests → exactly 4 core_sample; both buffers stay full with busy = 1. A single core_res_sample → exactly one further dispatch in the following cycle.
4. Simultaneous pop and push at inflight = 4: core_res_sample in the same cycle as a grant-eligible buffer → dispatch occurs and inflight stays 4.
5. Errors:
   - req_sample[1] while req_ready[1] = 0 → err_overrun = 2'b10, and the buffered data is unchanged at dispatch.
   - core_res_sample after reset with nothing issued → err_spurious = 1 and res_sample stays 0.
6. Async reset asserted mid-cycle with 2 in flight and both buffers full → all outputs reach their reset values immediately. After deassert, a new request from requester 0 dispatches in 2 cycles as in test 1.
